// File: rtl/alu_sequencer.sv
// alu_sequencer: clocked initiator for the combinational 32-bit ALU (command -> settle -> response).
// Optional reference-model checking with rsp_error when ALU_SEQ_CHECK_EN is defined.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [2:0]  alu_operation,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_zero
`ifdef ALU_SEQ_CHECK_EN
  ,
  output logic        rsp_error
`endif
);
  localparam logic [7:0] SETTLE_N = (SETTLE_CYCLES == 0) ? 8'd1 : 8'(SETTLE_CYCLES);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic        ovf_q, ovf_d, zero_q, zero_d;
  logic        load, cap;
  assign load = (state_q == IDLE) && cmd_valid;
  assign cap  = (state_q == SETTLE) && (cnt_q == 8'd1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cmd_valid ? SETTLE : IDLE;
      SETTLE:  state_d = (cnt_q == 8'd1) ? RESP : SETTLE;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    cnt_d  = load ? SETTLE_N : (state_q == SETTLE) ? cnt_q - 8'd1 : cnt_q;
    op_d   = load ? cmd_op : op_q;
    a_d    = load ? cmd_a : a_q;
    b_d    = load ? cmd_b : b_q;
    res_d  = cap ? alu_out : res_q;
    ovf_d  = cap ? alu_overflow : ovf_q;
    zero_d = cap ? (alu_out == 32'd0) : zero_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign alu_operation = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign rsp_result    = res_q;
  assign rsp_overflow  = ovf_q;
  assign rsp_zero      = zero_q;
`ifdef ALU_SEQ_CHECK_EN
  logic [31:0] sum, dif, m_res;
  logic        m_ovf, err_d, err_q;
  always_comb begin
    sum = a_q + b_q;
    dif = a_q - b_q;
    case (op_q)
      3'd0:    m_res = sum;
      3'd1:    m_res = dif;
      3'd2:    m_res = a_q ^ b_q;
      3'd3:    m_res = {31'd0, $signed(a_q) < $signed(b_q)};
      3'd4:    m_res = a_q & b_q;
      3'd5:    m_res = ~(a_q & b_q);
      3'd6:    m_res = ~(a_q | b_q);
      default: m_res = a_q | b_q;
    endcase
    // signed overflow: operand signs agree (add) / differ (sub) and result sign flips
    m_ovf = (op_q == 3'd0) ? (a_q[31] == b_q[31]) && (sum[31] != a_q[31]) :
            (op_q == 3'd1) ? (a_q[31] != b_q[31]) && (dif[31] != a_q[31]) : 1'b0;
    err_d = cap ? ((m_res != alu_out) || ((op_q[2:1] == 2'b00) && (m_ovf != alu_overflow))) : err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign rsp_error = err_q;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with a behavioural ALU behind two sequencers (SETTLE 4 and 0).
module tb_alu_sequencer;
  typedef struct packed {
    logic [31:0] r;
    logic        o;
    logic        z;
    logic        e;
  } exp_t;
  logic        clk = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, rsp_ready = 1'b1, force_en = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        cmd_ready, rsp_valid, rsp_overflow, rsp_zero, alu_overflow;
  logic [2:0]  alu_operation;
  logic [31:0] alu_a, alu_b, alu_out, rsp_result;
  logic [32:0] alu_r;
  logic        c0_valid = 1'b0, c0_ready, r0_valid, r0_ovf, r0_zero, a0_ovf;
  logic [2:0]  a0_op;
  logic [31:0] a0_a, a0_b, a0_out, r0_result;
  logic [32:0] a0_r;
`ifdef ALU_SEQ_CHECK_EN
  logic        rsp_error, r0_error;
`endif
  exp_t sb[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  function automatic logic [32:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s, d;
    s = a + b;
    d = a - b;
    case (op)
      3'd0:    return {(a[31] == b[31]) && (s[31] != a[31]), s};
      3'd1:    return {(a[31] != b[31]) && (d[31] != a[31]), d};
      3'd2:    return {1'b0, a ^ b};
      3'd3:    return {32'd0, $signed(a) < $signed(b)};
      3'd4:    return {1'b0, a & b};
      3'd5:    return {1'b0, ~(a & b)};
      3'd6:    return {1'b0, ~(a | b)};
      default: return {1'b0, a | b};
    endcase
  endfunction
  always_comb begin
    alu_r        = alu_f(alu_operation, alu_a, alu_b);
    alu_out      = force_en ? 32'h12345678 : alu_r[31:0];
    alu_overflow = alu_r[32];
    a0_r         = alu_f(a0_op, a0_a, a0_b);
    a0_out       = a0_r[31:0];
    a0_ovf       = a0_r[32];
  end
  alu_sequencer #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero)
`ifdef ALU_SEQ_CHECK_EN
    , .rsp_error(rsp_error)
`endif
  );
  alu_sequencer #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(c0_valid), .cmd_ready(c0_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_operation(a0_op), .alu_a(a0_a), .alu_b(a0_b),
    .alu_out(a0_out), .alu_overflow(a0_ovf),
    .rsp_valid(r0_valid), .rsp_ready(1'b1), .rsp_result(r0_result),
    .rsp_overflow(r0_ovf), .rsp_zero(r0_zero)
`ifdef ALU_SEQ_CHECK_EN
    , .rsp_error(r0_error)
`endif
  );
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1;
    total++;
    if ({cmd_ready, rsp_valid, alu_operation, alu_a, alu_b, rsp_result, rsp_overflow, rsp_zero} !==
        {1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: rdy=%b vld=%b op=%0d a=%h b=%h res=%h ovf=%b z=%b, required rdy=1 and all else 0",
               cmd_ready, rsp_valid, alu_operation, alu_a, alu_b, rsp_result, rsp_overflow, rsp_zero);
    end
`ifdef ALU_SEQ_CHECK_EN
    total++;
    if (rsp_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b required 0", rsp_error); end
`endif
  endtask
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eo, input logic ee);
    exp_t e;
    int n;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s_ready: cmd_ready=%b required 1", nm, cmd_ready); end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    sb.push_back('{r: er, o: eo, z: (er == 32'd0), e: ee});
    @(posedge clk) #1 cmd_valid = 1'b0;
    total++;
    if ({alu_operation, alu_a, alu_b} !== {op, a, b}) begin
      bad++;
      $display("FAIL %s_launch: op=%0d a=%h b=%h required op=%0d a=%h b=%h", nm, alu_operation, alu_a, alu_b, op, a, b);
    end
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk) #1; n++; end
    total++;
    if (n !== 4) begin bad++; $display("FAIL %s_latency: %0d cycles required 4", nm, n); end
    e = sb.pop_front();
    total++;
    if ({rsp_result, rsp_overflow, rsp_zero} !== {e.r, e.o, e.z}) begin
      bad++;
      $display("FAIL %s_rsp: res=%h ovf=%b z=%b required res=%h ovf=%b z=%b", nm, rsp_result, rsp_overflow, rsp_zero, e.r, e.o, e.z);
    end
`ifdef ALU_SEQ_CHECK_EN
    total++;
    if (rsp_error !== e.e) begin bad++; $display("FAIL %s_error: got %b required %b", nm, rsp_error, e.e); end
`endif
    @(posedge clk) #1;
    total++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      bad++;
      $display("FAIL %s_done: rsp_valid=%b cmd_ready=%b required 0 1", nm, rsp_valid, cmd_ready);
    end
  endtask
  task automatic test_directed;
    run_op("add_ovf", 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0);
    run_op("sub_zero", 3'd1, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op("slt_neg", 3'd3, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    run_op("nand", 3'd5, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0FFF0FF, 1'b0, 1'b0);
  endtask
  task automatic test_random;
    logic [31:0] a, b;
    logic [32:0] r;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = (i == 3) ? a : $urandom;
      r = alu_f(3'(i % 8), a, b);
      run_op("random", 3'(i % 8), a, b, r[31:0], r[32], 1'b0);
    end
  endtask
  task automatic test_backpressure;
    logic [31:0] r0, a0;
    exp_t e;
    int n;
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_op = 3'd2; cmd_a = 32'hAAAA5555; cmd_b = 32'h0F0F0F0F; cmd_valid = 1'b1;
    sb.push_back('{r: 32'hA5A55A5A, o: 1'b0, z: 1'b0, e: 1'b0});
    @(posedge clk) #1 cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk) #1; n++; end
    total++;
    if (n !== 4) begin bad++; $display("FAIL bp_latency: %0d cycles required 4", n); end
    r0 = rsp_result;
    a0 = alu_a;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmd_op = 3'd0; cmd_a = 32'(i + 1); cmd_b = 32'd1; cmd_valid = 1'b1;
      @(posedge clk) #1;
      total++;
      if ({rsp_valid, cmd_ready, rsp_result, alu_a} !== {1'b1, 1'b0, r0, a0}) begin
        bad++;
        $display("FAIL bp_hold: vld=%b rdy=%b res=%h a=%h required 1 0 %h %h", rsp_valid, cmd_ready, rsp_result, alu_a, r0, a0);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    e = sb.pop_front();
    total++;
    if ({rsp_result, rsp_overflow, rsp_zero} !== {e.r, e.o, e.z}) begin
      bad++;
      $display("FAIL bp_rsp: res=%h ovf=%b z=%b required %h %b %b", rsp_result, rsp_overflow, rsp_zero, e.r, e.o, e.z);
    end
    @(posedge clk) #1;
    total++;
    if ({rsp_valid, cmd_ready, alu_a, rsp_result} !== {1'b0, 1'b1, a0, r0}) begin
      bad++;
      $display("FAIL bp_release: vld=%b rdy=%b a=%h res=%h required 0 1 %h %h", rsp_valid, cmd_ready, alu_a, rsp_result, a0, r0);
    end
  endtask
  task automatic test_reset_mid_settle;
    int seen;
    @(negedge clk);
    cmd_op = 3'd7; cmd_a = 32'h13572468; cmd_b = 32'h1; cmd_valid = 1'b1;
    @(posedge clk) #1 cmd_valid = 1'b0;
    @(posedge clk) #1 reset = 1'b1;
    @(posedge clk) #1;
    total++;
    if ({rsp_valid, alu_a, alu_operation} !== {1'b0, 32'd0, 3'd0}) begin
      bad++;
      $display("FAIL midreset_clear: vld=%b a=%h op=%0d required 0 0 0", rsp_valid, alu_a, alu_operation);
    end
    @(negedge clk) reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk) #1;
      if (rsp_valid) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midreset_norsp: %0d response cycles required 0", seen); end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready: cmd_ready=%b required 1", cmd_ready); end
  endtask
  task automatic test_settle0;
    int n;
    @(negedge clk);
    total++;
    if (c0_ready !== 1'b1) begin bad++; $display("FAIL s0_ready: cmd_ready=%b required 1", c0_ready); end
    cmd_op = 3'd7; cmd_a = 32'hF0F00000; cmd_b = 32'h0000F0F0; c0_valid = 1'b1;
    @(posedge clk) #1 c0_valid = 1'b0;
    n = 0;
    while (!r0_valid && n < 50) begin @(posedge clk) #1; n++; end
    total++;
    if (n !== 1) begin bad++; $display("FAIL s0_latency: %0d cycles required 1", n); end
    total++;
    if ({r0_result, r0_ovf, r0_zero} !== {32'hF0F0F0F0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL s0_rsp: res=%h ovf=%b z=%b required f0f0f0f0 0 0", r0_result, r0_ovf, r0_zero);
    end
    @(posedge clk) #1;
    total++;
    if ({r0_valid, c0_ready} !== 2'b01) begin
      bad++;
      $display("FAIL s0_done: vld=%b rdy=%b required 0 1", r0_valid, c0_ready);
    end
  endtask
`ifdef ALU_SEQ_CHECK_EN
  task automatic test_check;
    force_en = 1'b1;
    run_op("chk_forced", 3'd4, 32'hFFFFFFFF, 32'd0, 32'h12345678, 1'b0, 1'b1);
    force_en = 1'b0;
    run_op("chk_clean", 3'd4, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask
`endif
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_settle();
    test_settle0();
`ifdef ALU_SEQ_CHECK_EN
    test_check();
`endif
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Clocked initiator for the 32-bit gate-level ALU: accepts operation commands over a valid/ready interface, drives the ALU's `operation`/`a`/`b` inputs from registers, and waits a programmable number of cycles for the gate-delay ripple to settle. It then captures `out`/`overflow` and returns them over a valid/ready response interface. It sits between the control/testbench side and the combinational ALU, making the ALU usable from synchronous logic.

## Interface
- `SETTLE_CYCLES`, default 4: cycles from operand launch to capture. Legal range is 1..255; a value of 0 is treated as 1.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command.
- `cmd_op` input 3: operation code. ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
- `cmd_a`, `cmd_b` input 32: operands.
- `alu_operation` output 3: registered drive to ALU `operation`.
- `alu_a`, `alu_b` output 32: registered drive to ALU `a`, `b`.
- `alu_out` input 32: ALU result.
- `alu_overflow` input 1: ALU overflow, meaningful for ADD/SUB only.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_result` output 32: captured result.
- `rsp_overflow` output 1: captured overflow.
- `rsp_zero` output 1: set when captured result == 0.
- `rsp_error` output 1: model mismatch; exists only with `ALU_SEQ_CHECK_EN`.

## Operation
- States: IDLE, SETTLE, RESP. Encoding is free.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`: latch `cmd_op`/`cmd_a`/`cmd_b` into `alu_operation`/`alu_a`/`alu_b`, load counter with `SETTLE_CYCLES`, go to SETTLE.
- SETTLE
  - `cmd_ready`=0. The `alu_*` outputs stay constant.
  - Counter decrements each edge.
  - On the edge where the counter equals 1: capture `alu_out` into `rsp_result`, `alu_overflow` into `rsp_overflow`, and `(alu_out==0)` into `rsp_zero`; set `rsp_valid`=1; go to RESP.
- RESP
  - `rsp_*` held stable while `rsp_valid & !rsp_ready`.
  - On `rsp_ready`: clear `rsp_valid`, go to IDLE. `rsp_result`/`rsp_overflow`/`rsp_zero` keep their last values.
- Commands presented outside IDLE are ignored, since `cmd_ready`=0. No command is accepted on the same edge a response completes.
- The `alu_*` outputs keep the last command's values in IDLE. They are not cleared after a response.
- Overflow is passed through unmodified. The ALU itself gates overflow to ADD/SUB; the sequencer does not re-gate it.
- Reset, from any state including mid-SETTLE:
  - State goes to IDLE.
  - `cmd_ready`=1 in the cycle after reset deasserts.
  - `rsp_valid`=0.
  - `alu_operation`=0, `alu_a`=0, `alu_b`=0.
  - `rsp_result`=0, `rsp_overflow`=0, `rsp_zero`=0, `rsp_error`=0.
  - Any in-flight command is discarded with no response.

## Timing
- Command accepted at edge E0. The `alu_*` outputs change just after E0.
- Capture at edge E0+`SETTLE_CYCLES`; `rsp_valid` is high from that edge.
- With `rsp_ready` held high, `rsp_valid` is high for exactly one cycle and `cmd_ready` returns the cycle after.
- Minimum command period: `SETTLE_CYCLES`+2 cycles.
- `SETTLE_CYCLES` must cover the ALU worst-case ripple, carry chain plus mux, at the chosen clock period. The integrator owns that choice; the block does not check it.
- `cmd_ready` and `rsp_valid` are registered/state-decoded only. They have no combinational path from `cmd_valid` or `rsp_ready`.

## Configuration
- Macro: `ALU_SEQ_CHECK_EN`.
- Defined:
  - Adds a behavioural reference model computed from the latched op/operands (32-bit wrap arithmetic; SLT is signed a<b giving 1 or 0).
  - Adds the `rsp_error` port. At capture, `rsp_error` = (model result != `alu_out`), or, for ADD/SUB only, (model overflow != `alu_overflow`).
  - `rsp_error` has the same hold/reset rules as `rsp_result`.
- Undefined: no model logic and no `rsp_error` port. All other behaviour is identical.

## Test plan
- ADD: a=0x7FFFFFFF, b=0x00000001, `SETTLE_CYCLES`=4 -> `rsp_valid` at E0+4; `rsp_result`=0x80000000, `rsp_overflow`=1, `rsp_zero`=0.
- SUB: a=5, b=5 -> `rsp_result`=0, `rsp_zero`=1, `rsp_overflow`=0. SLT: a=0xFFFFFFFF, b=1 -> `rsp_result`=1.
- Backpressure: `rsp_ready`=0 for 10 cycles after `rsp_valid` -> `rsp_*` stable, `cmd_ready`=0 throughout, a new `cmd_valid` is not accepted. Raising `rsp_ready` -> `cmd_ready`=1 the next cycle.
- Reset mid-SETTLE, asserted at E0+2 -> next cycle `rsp_valid`=0, `alu_a`=0, `cmd_ready`=1 after deassert. No response is ever produced for the discarded command.
- `SETTLE_CYCLES`=0 build: OR a=0xF0F00000, b=0x0000F0F0 -> treated as 1; `rsp_valid` at E0+1 with `rsp_result`=0xF0F0F0F0.
- `ALU_SEQ_CHECK_EN`: bench forces `alu_out`=0x12345678 for AND a=0xFFFFFFFF, b=0 -> `rsp_error`=1. With the real ALU across all 8 ops on random operands -> `rsp_error`=0.
